// File: rtl/audio_pkg.sv
// audio_pkg: shared widths, DAC midpoint and playback FSM encoding for the audio sample path.
// Revision: 1.0
`default_nettype none

package audio_pkg;

  localparam int SAMPLE_W = 16;
  localparam int DAC_W    = 8;
  localparam logic [DAC_W-1:0] DAC_MID = 8'h80;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_PLAY  = 2'd2
  } buf_state_e;

  // Signed PCM high byte to offset-binary DAC code.
  function automatic logic [DAC_W-1:0] to_dac(input logic [SAMPLE_W-1:0] word);
    return word[SAMPLE_W-1 -: DAC_W] ^ DAC_MID;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo_w16.sv
// sync_fifo_w16: single-clock 16-bit FIFO with synchronous clear and occupancy count.
// Revision: 1.0
`default_nettype none

module sync_fifo_w16
  import audio_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      push,
  input  logic [SAMPLE_W-1:0]       wdata,
  input  logic                      pop,
  output logic [SAMPLE_W-1:0]       rdata,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [SAMPLE_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]       count_q;
  logic                do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Pointers are exactly AW bits wide, so wrap modulo DEPTH is implicit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

`default_nettype wire

// File: rtl/audio_sample_buf.sv
// audio_sample_buf: byte-to-word PCM buffer with primed, rate-paced playback to an 8-bit DAC.
// Optional AUDIO_BUF_STATS_EN adds a saturating underrun counter output. Revision: 1.0
`default_nettype none

module audio_sample_buf
  import audio_pkg::*;
#(
  parameter int DEPTH      = 256,
  parameter int SAMPLE_DIV = 272
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [7:0]                 in_data,
  output logic                       in_ready,
  output logic [DAC_W-1:0]           dac_val,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       underrun
`ifdef AUDIO_BUF_STATS_EN
  ,
  output logic [15:0]                underrun_cnt
`endif
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(SAMPLE_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_DIV - 1);
  localparam logic [LW-1:0] PRIME_LVL = LW'(DEPTH / 2);

  buf_state_e          state_q, state_d;
  logic                phase_q, phase_d;
  logic [7:0]          lo_q, lo_d;
  logic [TW-1:0]       tcnt_q, tcnt_d;
  logic [DAC_W-1:0]    dac_q, dac_d;
  logic                underrun_q, underrun_d;

  logic                accept, push, pop, tick, starve;
  logic                fifo_full, fifo_empty;
  logic [SAMPLE_W-1:0] fifo_rdata;
  logic [LW-1:0]       fifo_count;

  sync_fifo_w16 #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (flush),
    .push  (push),
    .wdata ({in_data, lo_q}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign in_ready = ~fifo_full;
  assign accept   = in_valid & ~fifo_full;
  assign push     = accept & phase_q & ~flush;
  assign tick     = enable & (tcnt_q == TICK_LAST);
  assign pop      = (state_q == ST_PLAY) & tick & ~fifo_empty & ~flush;
  assign starve   = (state_q == ST_PLAY) & tick & fifo_empty & ~flush;

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    lo_d       = lo_q;
    tcnt_d     = '0;
    dac_d      = dac_q;
    underrun_d = starve;

    if (enable) tcnt_d = (tcnt_q == TICK_LAST) ? '0 : tcnt_q + 1'b1;

    if (flush) begin
      phase_d = 1'b0;
    end else if (accept) begin
      phase_d = ~phase_q;
      if (!phase_q) lo_d = in_data;
    end

    if (!enable) begin
      state_d = ST_IDLE;
    end else if (flush) begin
      state_d = ST_PRIME;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = ST_PRIME;
        ST_PRIME: if (fifo_count >= PRIME_LVL) state_d = ST_PLAY;
        ST_PLAY:  if (starve) state_d = ST_PRIME;
        default:  state_d = ST_IDLE;
      endcase
    end

    if (!enable)  dac_d = DAC_MID;
    else if (pop) dac_d = to_dac(fifo_rdata);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      phase_q    <= 1'b0;
      lo_q       <= '0;
      tcnt_q     <= '0;
      dac_q      <= DAC_MID;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      lo_q       <= lo_d;
      tcnt_q     <= tcnt_d;
      dac_q      <= dac_d;
      underrun_q <= underrun_d;
    end
  end

  assign dac_val  = dac_q;
  assign level    = fifo_count;
  assign underrun = underrun_q;

`ifdef AUDIO_BUF_STATS_EN
  logic [15:0] ucnt_q, ucnt_d;

  always_comb begin
    ucnt_d = ucnt_q;
    if (flush) ucnt_d = '0;
    else if (starve && ucnt_q != 16'hFFFF) ucnt_d = ucnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ucnt_q <= '0;
    else     ucnt_q <= ucnt_d;
  end

  assign underrun_cnt = ucnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_audio_sample_buf.sv
// tb_audio_sample_buf: directed stimulus with a queue-based reference model compared every cycle.
// Revision: 1.0
`default_nettype none

module tb_audio_sample_buf;

  localparam int DEPTH      = 8;
  localparam int SAMPLE_DIV = 4;
  localparam int LW         = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          enable = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready;
  logic [7:0]    dac_val;
  logic [LW-1:0] level;
  logic          underrun;
`ifdef AUDIO_BUF_STATS_EN
  logic [15:0]   underrun_cnt;
`endif

  audio_sample_buf #(.DEPTH(DEPTH), .SAMPLE_DIV(SAMPLE_DIV)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .dac_val      (dac_val),
    .level        (level),
    .underrun     (underrun)
`ifdef AUDIO_BUF_STATS_EN
    ,
    .underrun_cnt (underrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: words held in a queue, playback mode as a small integer.
  localparam int M_IDLE = 0, M_PRIME = 1, M_PLAY = 2;
  logic [15:0] mq[$];
  int          m_state = M_IDLE;
  int          m_tcnt  = 0;
  bit          m_phase = 1'b0;
  logic [7:0]  m_lo    = 8'h00;
  logic [7:0]  m_dac   = 8'h80;
  bit          m_under = 1'b0;
  int          m_ucnt  = 0;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        mq.delete();
        m_state = M_IDLE; m_tcnt = 0; m_phase = 1'b0;
        m_dac = 8'h80; m_under = 1'b0; m_ucnt = 0;
      end else begin
        automatic int  n0     = mq.size();
        automatic bit  tk     = enable && (m_tcnt == SAMPLE_DIV - 1);
        automatic bit  acc    = in_valid && (n0 < DEPTH);
        automatic bit  in_pl  = (m_state == M_PLAY) && tk && !flush;
        automatic bit  starve = in_pl && (n0 == 0);
        automatic logic [15:0] w;
        if (in_pl && n0 > 0) begin
          w = mq.pop_front();
          m_dac = w[15:8] ^ 8'h80;
        end
        if (flush) begin
          mq.delete();
          m_phase = 1'b0;
        end else if (acc) begin
          if (!m_phase) m_lo = in_data;
          else mq.push_back({in_data, m_lo});
          m_phase = !m_phase;
        end
        m_tcnt = enable ? (m_tcnt + 1) % SAMPLE_DIV : 0;
        if (!enable) m_state = M_IDLE;
        else if (flush) m_state = M_PRIME;
        else if (m_state == M_IDLE) m_state = M_PRIME;
        else if (m_state == M_PRIME && n0 >= DEPTH / 2) m_state = M_PLAY;
        else if (m_state == M_PLAY && starve) m_state = M_PRIME;
        if (!enable) m_dac = 8'h80;
        m_under = starve;
        if (flush) m_ucnt = 0;
        else if (starve && m_ucnt < 16'hFFFF) m_ucnt++;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
      chk("level",    32'(level),    32'(mq.size()));
      chk("dac_val",  32'(dac_val),  32'(m_dac));
      chk("underrun", 32'(underrun), 32'(m_under));
`ifdef AUDIO_BUF_STATS_EN
      chk("underrun_cnt", 32'(underrun_cnt), 32'(m_ucnt));
`endif
    end
  end

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting, got no event expected event at %0t", name, $time);
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit done = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    for (int i = 0; i < 50 && !done; i++) begin
      if (in_ready) done = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!done) timeout("send_byte");
  endtask

  task automatic wait_level(input int v, input int max_cyc);
    bit done = 1'b0;
    for (int i = 0; i < max_cyc && !done; i++) begin
      @(negedge clk);
      if (level == LW'(v)) done = 1'b1;
    end
    if (!done) timeout("wait_level");
  endtask

  task automatic wait_dac_change(input logic [7:0] from, input int max_cyc);
    bit done = 1'b0;
    for (int i = 0; i < max_cyc && !done; i++) begin
      @(negedge clk);
      if (dac_val !== from) done = 1'b1;
    end
    if (!done) timeout("wait_dac");
  endtask

  task automatic wait_underrun(input int max_cyc);
    bit done = 1'b0;
    for (int i = 0; i < max_cyc && !done; i++) begin
      @(negedge clk);
      if (underrun === 1'b1) done = 1'b1;
    end
    if (!done) timeout("wait_underrun");
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b1;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_dac",      32'(dac_val),  32'h80);
    chk("rst_level",    32'(level),    32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_underrun", 32'(underrun), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Priming: nothing plays until half full, first sample is 0x1234 -> 0x92.
    enable = 1'b1;
    send_byte(8'h34); send_byte(8'h12);
    send_byte(8'h78); send_byte(8'h56);
    chk("prime_level2", 32'(level),   32'd2);
    chk("prime_nopop",  32'(dac_val), 32'h80);
    send_byte(8'hBC); send_byte(8'h9A);
    send_byte(8'hF0); send_byte(8'hDE);
    wait_dac_change(8'h80, 30);
    chk("first_sample", 32'(dac_val), 32'h92);

    // Drain to starvation: last word 0xDEF0 stays on the DAC.
    wait_underrun(40);
    chk("under_dac",   32'(dac_val), 32'h5E);
    chk("under_level", 32'(level),   32'd0);
`ifdef AUDIO_BUF_STATS_EN
    chk("under_cnt", 32'(underrun_cnt), 32'd1);
`endif
    @(negedge clk);
    chk("under_pulse1", 32'(underrun), 32'd0);

    // Fill to full with in_valid held high.
    enable   = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 24; i++) begin
      in_data = 8'(i + 8'h40);
      @(negedge clk);
    end
    chk("full_level", 32'(level),    32'd8);
    chk("full_ready", 32'(in_ready), 32'd0);
    enable = 1'b1;
    wait_level(7, 20);
    chk("ready_after_pop", 32'(in_ready), 32'd1);
    in_valid = 1'b0;

    // Push of a high byte landing on a tick pop leaves level unchanged.
    enable = 1'b0;
    @(negedge clk);
    pulse_flush();
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'h05); send_byte(8'h06); send_byte(8'h07); send_byte(8'h08);
    send_byte(8'h11);
    enable = 1'b1;
    wait_level(3, 30);
    repeat (3) @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h22;
    @(negedge clk);
    in_valid = 1'b0;
    chk("push_pop_level", 32'(level), 32'd3);

    // Flush discards a dangling low byte; next pair forms 0xCDAB.
    enable = 1'b0;
    @(negedge clk);
    send_byte(8'h11);
    pulse_flush();
    chk("flush_level", 32'(level), 32'd0);
    send_byte(8'hAB); send_byte(8'hCD);
    chk("flush_word_level", 32'(level), 32'd1);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    send_byte(8'h04); send_byte(8'h05); send_byte(8'h06);
    enable = 1'b1;
    wait_dac_change(8'h80, 30);
    chk("flush_word_dac", 32'(dac_val), 32'h4D);

    // Asynchronous reset mid-playback takes effect between clock edges.
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_dac",      32'(dac_val),  32'h80);
    chk("arst_level",    32'(level),    32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_underrun", 32'(underrun), 32'd0);
`ifdef AUDIO_BUF_STATS_EN
    chk("arst_cnt", 32'(underrun_cnt), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
